atm_session_ctrl: RTL and testbench

//  Parametrised ATM session controller; next generation of the hard-wired ATM FSM under the VGA/music/7-seg top.

---
 rtl/atm_session_ctrl.sv | 264 ++++++++++++++++++++++++++
 tb/tb_atm_session_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl: PIN-gated ATM session controller with per-card balances,
// per-card wrong-PIN lockout, digit delete and a dispense handshake.
// Build option: define TIMEOUT_EN to add the inactivity timeout (and the
// TIMEOUT_CYC parameter); without it every state waits indefinitely.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE 0   | no session, waiting for exactly one card
// PIN 1    | collecting PIN digits for the latched card
// MENU 2   | authenticated, waiting for an amount key or 'no'
// DISP 3   | cash presented, waiting for take_money
// RECEIPT 4| transaction done, 'yes' for another, 'no' to finish
// NOFUNDS 5| requested amount exceeded balance, any key returns to MENU
// LOCKED 6 | card locked out, held until the card is removed
// DONE 7   | session finished, held until the card is removed
module atm_session_ctrl #(
   parameter int PIN_LEN   = 6,
   parameter int NUM_CARDS = 5,
   parameter int MAX_TRIES = 3,
   parameter int BAL_W     = 16,
   parameter int INIT_BAL  = 5000
`ifdef TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYC = 2**24
`endif
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_CARDS-1:0]           card_in,
   input  logic [NUM_CARDS*4*PIN_LEN-1:0] pin_table,
   input  logic                           key_vld,
   input  logic [4:0]                     key_code,
   input  logic                           take_money,
   output logic [3:0]                     state,
   output logic [3:0]                     which_place,
   output logic [2:0]                     tries_left,
   output logic                           disp_vld,
   output logic [BAL_W-1:0]               disp_amt,
   output logic [BAL_W-1:0]               balance,
   output logic                           warning
);

   localparam int PIN_W = 4 * PIN_LEN;
   localparam int IDX_W = (NUM_CARDS > 1) ? $clog2(NUM_CARDS) : 1;

   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_PIN     = 4'd1;
   localparam logic [3:0] S_MENU    = 4'd2;
   localparam logic [3:0] S_DISP    = 4'd3;
   localparam logic [3:0] S_RECEIPT = 4'd4;
   localparam logic [3:0] S_NOFUNDS = 4'd5;
   localparam logic [3:0] S_LOCKED  = 4'd6;
   localparam logic [3:0] S_DONE    = 4'd7;

   localparam logic [4:0] K_ENTER = 5'd10;
   localparam logic [4:0] K_CLEAR = 5'd11;
   localparam logic [4:0] K_BACK  = 5'd12;
   localparam logic [4:0] K_A     = 5'd13;
   localparam logic [4:0] K_F     = 5'd18;
   localparam logic [4:0] K_YES   = 5'd19;
   localparam logic [4:0] K_NO    = 5'd20;

   logic [3:0]           state_q, state_d;
   logic [3:0]           place_q, place_d;
   logic [PIN_W-1:0]     pin_q, pin_d, pin_ref;
   logic [IDX_W-1:0]     idx_q, idx_d, card_idx;
   logic [BAL_W-1:0]     bal_q [NUM_CARDS];
   logic [BAL_W-1:0]     bal_d [NUM_CARDS];
   logic [2:0]           fail_q [NUM_CARDS];
   logic [2:0]           fail_d [NUM_CARDS];
   logic [NUM_CARDS-1:0] lock_q, lock_d;
   logic                 dvld_q, dvld_d;
   logic [BAL_W-1:0]     damt_q, damt_d;
   logic [BAL_W-1:0]     bal_out_q, bal_out_d;
   logic [2:0]           tries_q, tries_d;
   logic                 warn_q, warn_d;
   logic [BAL_W-1:0]     amt_sel;
   logic                 card_ok, key_ev, to_fire;

   // Card presence check, one-hot encode and PIN lookup for the latched card
   always_comb begin
      card_ok  = (card_in != '0) && ((card_in & (card_in - NUM_CARDS'(1))) == '0);
      card_idx = '0;
      pin_ref  = '0;
      for (int k = 0; k < NUM_CARDS; k++) begin
         if (card_in[k]) card_idx = IDX_W'(k);
         if (idx_q == IDX_W'(k)) pin_ref = pin_table[k*PIN_W +: PIN_W];
      end
   end

   // Withdrawal amount for keys a..f
   always_comb begin
      case (key_code)
         5'd13:   amt_sel = BAL_W'(100);
         5'd14:   amt_sel = BAL_W'(200);
         5'd15:   amt_sel = BAL_W'(500);
         5'd16:   amt_sel = BAL_W'(1000);
         5'd17:   amt_sel = BAL_W'(2000);
         5'd18:   amt_sel = BAL_W'(5000);
         default: amt_sel = '0;
      endcase
   end

`ifdef TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TO_W-1:0] to_q, to_d;

   assign to_fire = (to_q == '0) && !key_vld && !take_money &&
                    ((state_q == S_PIN) || (state_q == S_MENU) ||
                     (state_q == S_RECEIPT) || (state_q == S_NOFUNDS));

   // Idle down-counter: reload on any activity or state change, hold at terminal count
   always_comb begin
      if (key_vld || take_money || (state_d != state_q)) to_d = TO_W'(TIMEOUT_CYC - 1);
      else if (to_q != '0)                                to_d = to_q - TO_W'(1);
      else                                                to_d = to_q;
   end

   // Timer register
   always_ff @(posedge clk) begin
      if (reset) to_q <= TO_W'(TIMEOUT_CYC - 1);
      else       to_q <= to_d;
   end
`else
   assign to_fire = 1'b0;
`endif

   // Session FSM; card removal outranks everything except an open dispense
   always_comb begin
      state_d = state_q;
      place_d = place_q;
      pin_d   = pin_q;
      idx_d   = idx_q;
      bal_d   = bal_q;
      fail_d  = fail_q;
      lock_d  = lock_q;
      dvld_d  = dvld_q;
      damt_d  = damt_q;
      key_ev  = key_vld && !take_money;
      if ((state_q != S_IDLE) && (state_q != S_DISP) && !card_ok) begin
         state_d = S_IDLE;
         place_d = '0;
         pin_d   = '0;
      end else if (to_fire) begin
         state_d = S_DONE;
         place_d = '0;
         pin_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: if (card_ok) begin
               idx_d   = card_idx;
               state_d = lock_q[card_idx] ? S_LOCKED : S_PIN;
               place_d = '0;
               pin_d   = '0;
            end
            S_PIN: if (key_ev) begin
               if (key_code <= 5'd9) begin
                  if (place_q < 4'(PIN_LEN)) begin
                     pin_d[(PIN_LEN - 1 - int'(place_q))*4 +: 4] = key_code[3:0];
                     place_d = place_q + 4'd1;
                  end
               end else if (key_code == K_BACK) begin
                  if (place_q != 4'd0) begin
                     pin_d[(PIN_LEN - int'(place_q))*4 +: 4] = 4'd0;
                     place_d = place_q - 4'd1;
                  end
               end else if (key_code == K_CLEAR) begin
                  place_d = '0;
                  pin_d   = '0;
               end else if ((key_code == K_ENTER) && (place_q == 4'(PIN_LEN))) begin
                  place_d = '0;
                  pin_d   = '0;
                  if (pin_q == pin_ref) begin
                     fail_d[idx_q] = 3'd0;
                     state_d       = S_MENU;
                  end else begin
                     fail_d[idx_q] = fail_q[idx_q] + 3'd1;
                     if ((fail_q[idx_q] + 3'd1) == 3'(MAX_TRIES)) begin
                        lock_d[idx_q] = 1'b1;
                        state_d       = S_LOCKED;
                     end
                  end
               end
            end
            S_MENU: if (key_ev) begin
               if ((key_code >= K_A) && (key_code <= K_F)) begin
                  if (amt_sel <= bal_q[idx_q]) begin
                     state_d = S_DISP;
                     dvld_d  = 1'b1;
                     damt_d  = amt_sel;
                  end else begin
                     state_d = S_NOFUNDS;
                  end
               end else if (key_code == K_NO) begin
                  state_d = S_DONE;
               end
            end
            S_DISP: if (take_money) begin
               bal_d[idx_q] = bal_q[idx_q] - damt_q;
               dvld_d       = 1'b0;
               damt_d       = '0;
               state_d      = S_RECEIPT;
            end
            S_RECEIPT: if (key_ev) begin
               if (key_code == K_YES)     state_d = S_MENU;
               else if (key_code == K_NO) state_d = S_DONE;
            end
            S_NOFUNDS: if (key_ev) state_d = S_MENU;
            S_LOCKED, S_DONE: ;
            default: state_d = S_IDLE;
         endcase
      end
      warn_d = (state_d == S_LOCKED) || (state_d == S_NOFUNDS);
      if (state_d == S_IDLE) begin
         bal_out_d = '0;
         tries_d   = '0;
      end else begin
         bal_out_d = bal_d[idx_d];
         tries_d   = 3'(MAX_TRIES) - fail_d[idx_d];
      end
   end

   // State, per-card bookkeeping and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         place_q   <= '0;
         pin_q     <= '0;
         idx_q     <= '0;
         lock_q    <= '0;
         dvld_q    <= 1'b0;
         damt_q    <= '0;
         bal_out_q <= '0;
         tries_q   <= '0;
         warn_q    <= 1'b0;
         for (int k = 0; k < NUM_CARDS; k++) begin
            bal_q[k]  <= BAL_W'(INIT_BAL);
            fail_q[k] <= '0;
         end
      end else begin
         state_q   <= state_d;
         place_q   <= place_d;
         pin_q     <= pin_d;
         idx_q     <= idx_d;
         lock_q    <= lock_d;
         dvld_q    <= dvld_d;
         damt_q    <= damt_d;
         bal_out_q <= bal_out_d;
         tries_q   <= tries_d;
         warn_q    <= warn_d;
         bal_q     <= bal_d;
         fail_q    <= fail_d;
      end
   end

   assign state       = state_q;
   assign which_place = place_q;
   assign tries_left  = tries_q;
   assign disp_vld    = dvld_q;
   assign disp_amt    = damt_q;
   assign balance     = bal_out_q;
   assign warning     = warn_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed scenario bench for atm_session_ctrl. Each stimulus cycle queues the
// hand-computed output set expected after the next clock edge; an independent
// monitor pops and compares one entry per cycle.
module tb_atm_session_ctrl;

   localparam logic [4:0] NONE = 5'b00000;
   localparam logic [4:0] C0   = 5'b00001;
   localparam logic [4:0] C1   = 5'b00010;
   localparam logic [4:0] C3   = 5'b01000;
   localparam logic [4:0] K_ENT = 5'd10, K_CLR = 5'd11, K_BK = 5'd12;
   localparam logic [4:0] K_A = 5'd13, K_C = 5'd15, K_D = 5'd16, K_F = 5'd18;
   localparam logic [4:0] K_Y = 5'd19, K_N = 5'd20;

   typedef struct packed {
      logic [3:0]  st;
      logic [3:0]  pl;
      logic [2:0]  tr;
      logic        dv;
      logic [15:0] da;
      logic [15:0] bl;
      logic        wn;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [4:0]   card_in = '0;
   logic [119:0] pin_table = {24'h000000, 24'h987654, 24'h000000, 24'h654321, 24'h123456};
   logic         key_vld = 1'b0;
   logic [4:0]   key_code = '0;
   logic         take_money = 1'b0;
   logic [3:0]   state, which_place;
   logic [2:0]   tries_left;
   logic         disp_vld, warning;
   logic [15:0]  disp_amt, balance;

   exp_t  exp_q[$];
   string name_q[$];
   int    total = 0;
   int    bad = 0;

   atm_session_ctrl dut (
      .clk(clk), .reset(reset), .card_in(card_in), .pin_table(pin_table),
      .key_vld(key_vld), .key_code(key_code), .take_money(take_money),
      .state(state), .which_place(which_place), .tries_left(tries_left),
      .disp_vld(disp_vld), .disp_amt(disp_amt), .balance(balance), .warning(warning)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(int st, int pl, int tr, int dv, int da, int bl, int wn);
      exp_t e;
      e.st = 4'(st); e.pl = 4'(pl); e.tr = 3'(tr); e.dv = 1'(dv);
      e.da = 16'(da); e.bl = 16'(bl); e.wn = 1'(wn);
      return e;
   endfunction

   task automatic drv(input string nm, input logic rst, input logic [4:0] card,
                      input logic kv, input logic [4:0] kc, input logic tm, input exp_t e);
      @(negedge clk);
      reset = rst; card_in = card; key_vld = kv; key_code = kc; take_money = tm;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic key(input string nm, input logic [4:0] card, input logic [4:0] kc, input exp_t e);
      drv(nm, 1'b0, card, 1'b1, kc, 1'b0, e);
   endtask

   task automatic idle(input string nm, input logic [4:0] card, input exp_t e);
      drv(nm, 1'b0, card, 1'b0, 5'd0, 1'b0, e);
   endtask

   task automatic take(input string nm, input logic [4:0] card, input exp_t e);
      drv(nm, 1'b0, card, 1'b0, 5'd0, 1'b1, e);
   endtask

   task automatic enter_pin(input logic [4:0] card, input logic [23:0] pin, input int tries, input int bal);
      for (int i = 0; i < 6; i++) begin
         logic [3:0] d;
         d = pin[(5-i)*4 +: 4];
         key($sformatf("digit%0d", i), card, {1'b0, d}, mk(1, i+1, tries, 0, 0, bal, 0));
      end
   endtask

   // Monitor: one queued expectation is due right after each clock edge
   initial begin
      forever begin
         exp_t  e;
         exp_t  a;
         string nm;
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {state, which_place, tries_left, disp_vld, disp_amt, balance, warning};
            total++;
            if (a !== e) begin
               bad++;
               $display("FAIL %s: got st=%0d pl=%0d tr=%0d dv=%0d amt=%0d bal=%0d wn=%0d want st=%0d pl=%0d tr=%0d dv=%0d amt=%0d bal=%0d wn=%0d",
                        nm, a.st, a.pl, a.tr, a.dv, a.da, a.bl, a.wn,
                        e.st, e.pl, e.tr, e.dv, e.da, e.bl, e.wn);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t z;
      z = mk(0, 0, 0, 0, 0, 0, 0);
      drv("reset_a", 1'b1, NONE, 1'b0, 5'd0, 1'b0, z);
      drv("reset_b", 1'b1, C0, 1'b0, 5'd0, 1'b0, z);

      // card 0: entry editing, correct PIN, withdrawals
      idle("insert_c0", C0, mk(1, 0, 3, 0, 0, 5000, 0));
      key("d1", C0, 5'd1, mk(1, 1, 3, 0, 0, 5000, 0));
      key("d2", C0, 5'd2, mk(1, 2, 3, 0, 0, 5000, 0));
      key("d3", C0, 5'd3, mk(1, 3, 3, 0, 0, 5000, 0));
      key("back", C0, K_BK, mk(1, 2, 3, 0, 0, 5000, 0));
      key("d4", C0, 5'd4, mk(1, 3, 3, 0, 0, 5000, 0));
      key("clear", C0, K_CLR, mk(1, 0, 3, 0, 0, 5000, 0));
      key("back_at_0", C0, K_BK, mk(1, 0, 3, 0, 0, 5000, 0));
      key("enter_empty", C0, K_ENT, mk(1, 0, 3, 0, 0, 5000, 0));
      enter_pin(C0, 24'h123456, 3, 5000);
      key("digit7_full", C0, 5'd7, mk(1, 6, 3, 0, 0, 5000, 0));
      key("enter_ok", C0, K_ENT, mk(2, 0, 3, 0, 0, 5000, 0));
      key("menu_digit", C0, 5'd5, mk(2, 0, 3, 0, 0, 5000, 0));
      key("sel_500", C0, K_C, mk(3, 0, 3, 1, 500, 5000, 0));
      idle("disp_wait", C0, mk(3, 0, 3, 1, 500, 5000, 0));
      key("disp_key", C0, K_Y, mk(3, 0, 3, 1, 500, 5000, 0));
      take("take_500", C0, mk(4, 0, 3, 0, 0, 4500, 0));
      drv("take_and_key", 1'b0, C0, 1'b1, K_N, 1'b1, mk(4, 0, 3, 0, 0, 4500, 0));
      key("rcpt_yes", C0, K_Y, mk(2, 0, 3, 0, 0, 4500, 0));
      key("sel_5000_nofunds", C0, K_F, mk(5, 0, 3, 0, 0, 4500, 1));
      key("nofunds_any", C0, 5'd3, mk(2, 0, 3, 0, 0, 4500, 0));
      key("sel_1000", C0, K_D, mk(3, 0, 3, 1, 1000, 4500, 0));
      idle("disp_card_out", NONE, mk(3, 0, 3, 1, 1000, 4500, 0));
      take("take_card_out", NONE, mk(4, 0, 3, 0, 0, 3500, 0));
      idle("abort_after_take", NONE, z);

      // card 1: three wrong PINs lock it, lock persists across reinsertion
      idle("insert_c1", C1, mk(1, 0, 3, 0, 0, 5000, 0));
      for (int t = 3; t >= 1; t--) begin
         enter_pin(C1, 24'h111111, t, 5000);
         if (t > 1) key("enter_bad", C1, K_ENT, mk(1, 0, t-1, 0, 0, 5000, 0));
         else       key("enter_lock", C1, K_ENT, mk(6, 0, 0, 0, 0, 5000, 1));
      end
      key("locked_key", C1, 5'd1, mk(6, 0, 0, 0, 0, 5000, 1));
      idle("locked_out", NONE, z);
      idle("reinsert_locked", C1, mk(6, 0, 0, 0, 0, 5000, 1));
      idle("out_c1", NONE, z);
      idle("two_cards", 5'b00011, z);

      // card 0 again: balance persisted, removal in PIN and MENU
      idle("insert_c0_again", C0, mk(1, 0, 3, 0, 0, 3500, 0));
      key("p1", C0, 5'd1, mk(1, 1, 3, 0, 0, 3500, 0));
      idle("pin_card_out", NONE, z);
      idle("reinsert_c0", C0, mk(1, 0, 3, 0, 0, 3500, 0));
      enter_pin(C0, 24'h123456, 3, 3500);
      key("enter_ok2", C0, K_ENT, mk(2, 0, 3, 0, 0, 3500, 0));
      idle("menu_card_out", NONE, z);

      // card 3: wrong then right PIN restores tries, exact-balance withdrawal
      idle("insert_c3", C3, mk(1, 0, 3, 0, 0, 5000, 0));
      enter_pin(C3, 24'h000000, 3, 5000);
      key("c3_bad", C3, K_ENT, mk(1, 0, 2, 0, 0, 5000, 0));
      enter_pin(C3, 24'h987654, 2, 5000);
      key("c3_ok", C3, K_ENT, mk(2, 0, 3, 0, 0, 5000, 0));
      key("sel_5000_exact", C3, K_F, mk(3, 0, 3, 1, 5000, 5000, 0));
      take("take_5000", C3, mk(4, 0, 3, 0, 0, 0, 0));
      key("rcpt_yes2", C3, K_Y, mk(2, 0, 3, 0, 0, 0, 0));
      key("sel_100_empty", C3, K_A, mk(5, 0, 3, 0, 0, 0, 1));
      key("nofunds_no", C3, K_N, mk(2, 0, 3, 0, 0, 0, 0));
      key("menu_no", C3, K_N, mk(7, 0, 3, 0, 0, 0, 0));
      key("done_key", C3, K_Y, mk(7, 0, 3, 0, 0, 0, 0));
      idle("done_out", NONE, z);

      @(negedge clk);
      key_vld = 1'b0; take_money = 1'b0; card_in = '0;
      for (int i = 0; i < 10; i++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk);
         #2;
      end
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
